// File: rtl/hs_pkg.sv
// Shared definitions for the hiscore RAM port: FSM encodings and the shared-RAM memory map.
package hs_pkg;

   typedef logic [1:0] hs_state_t;

   localparam hs_state_t StIdle    = 2'd0;
   localparam hs_state_t StDrain   = 2'd1;
   localparam hs_state_t StGranted = 2'd2;
   localparam hs_state_t StRelease = 2'd3;

   localparam logic [15:0] HsBase   = 16'h8000;
   localparam int unsigned HsBankAw = 10;

endpackage

// File: rtl/hs_ram_port_decode.sv
// Combinational decode of a hiscore byte address into bank, bank offset and window hit.
module hs_addr_decode
   import hs_pkg::*;
#(
   parameter int unsigned      HS_AW     = 16,
   parameter int unsigned      BANK_AW   = HsBankAw,
   parameter int unsigned      NUM_BANKS = 3,
   parameter logic [HS_AW-1:0] BASE      = HsBase
) (
   input  logic [HS_AW-1:0]   address,
   output logic               in_window,
   output logic [1:0]         bank,
   output logic [BANK_AW-1:0] bank_addr
);

   logic [HS_AW-1:0] off;
   logic [HS_AW-1:0] bank_idx;

   // Banks sit on a 2 KB stride; the upper 1 KB of each stride is a mirror and is rejected.
   always_comb begin
      off       = address - BASE;
      bank_idx  = off >> (BANK_AW + 1);
      bank      = off[BANK_AW+1 +: 2];
      bank_addr = off[BANK_AW-1:0];
      in_window = (address >= BASE) && !off[BANK_AW] && (bank_idx < HS_AW'(NUM_BANKS));
   end

endmodule

// File: rtl/hs_ram_port.sv
// Hiscore RAM port: takes the shared work RAMs from the halted CPUs and serves hiscore
// byte reads/writes on them.
module hs_ram_port
   import hs_pkg::*;
#(
   parameter int unsigned      HS_AW     = 16,
   parameter int unsigned      BANK_AW   = HsBankAw,
   parameter int unsigned      NUM_BANKS = 3,
   parameter logic [HS_AW-1:0] BASE      = HsBase,
   parameter int unsigned      GUARD     = 4
) (
   input  logic                   clock_18,
   input  logic                   reset,
   input  logic                   hs_access,
   input  logic [HS_AW-1:0]       hs_address,
   input  logic [7:0]             hs_data_in,
   input  logic                   hs_write,
   output logic [7:0]             hs_data_out,
   output logic                   hs_granted,
   output logic                   hs_drop,
   input  logic                   cpu_halted,
   input  logic [BANK_AW-1:0]     cpu_addr,
   input  logic [7:0]             cpu_din,
   input  logic [NUM_BANKS-1:0]   cpu_we,
   output logic [BANK_AW-1:0]     ram_addr,
   output logic [7:0]             ram_din,
   output logic [NUM_BANKS-1:0]   ram_we,
   input  logic [8*NUM_BANKS-1:0] ram_dout
);

   localparam int unsigned CntW = $clog2(GUARD + 1);

   hs_state_t       state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            granted;
   logic            hs_wr_ok;

   logic               dec_in_window;
   logic [1:0]         dec_bank;
   logic [BANK_AW-1:0] dec_bank_addr;

   logic       rd_valid_q;
   logic       rd_win_q;
   logic [1:0] rd_bank_q;
   logic [7:0] rd_data;

   hs_addr_decode #(
      .HS_AW     (HS_AW),
      .BANK_AW   (BANK_AW),
      .NUM_BANKS (NUM_BANKS),
      .BASE      (BASE)
   ) u_decode (
      .address   (hs_address),
      .in_window (dec_in_window),
      .bank      (dec_bank),
      .bank_addr (dec_bank_addr)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (hs_access) begin
               state_d = StDrain;
               cnt_d   = '0;
            end
         end
         StDrain: begin
            if (!hs_access) begin
               state_d = StIdle;
            end else if (!cpu_halted) begin
               cnt_d = '0;
            end else if (cnt_q == CntW'(GUARD - 1)) begin
               state_d = StGranted;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StGranted: begin
            if (!hs_access) state_d = StRelease;
         end
         StRelease: state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   // Reset hands the RAMs back to the CPUs in the same cycle, even mid-grant.
   assign granted    = (state_q == StGranted) && !reset;
   assign hs_granted = granted;
   assign hs_wr_ok   = hs_write && granted && dec_in_window;

   always_comb begin
      ram_addr = cpu_addr;
      ram_din  = cpu_din;
      ram_we   = cpu_we;
      if (granted) begin
         ram_addr = dec_bank_addr;
         ram_din  = hs_data_in;
         ram_we   = hs_wr_ok ? (NUM_BANKS'(1) << dec_bank) : '0;
      end
      if (reset) ram_we = '0;
   end

   always_comb begin
      rd_data = '0;
      for (int unsigned n = 0; n < NUM_BANKS; n++) begin
         if (rd_bank_q == n[1:0]) rd_data = ram_dout[8*n +: 8];
      end
   end

   always_ff @(posedge clock_18) begin
      if (reset) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         hs_drop     <= 1'b0;
         hs_data_out <= '0;
         rd_valid_q  <= 1'b0;
         rd_win_q    <= 1'b0;
         rd_bank_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (hs_write && !hs_wr_ok) hs_drop <= 1'b1;
         // Bank select follows the address by one cycle to line up with the RAM read.
         rd_valid_q <= granted;
         rd_win_q   <= dec_in_window;
         rd_bank_q  <= dec_bank;
         if (rd_valid_q) hs_data_out <= rd_win_q ? rd_data : 8'h00;
      end
   end

endmodule

// File: tb/tb_hs_ram_port.sv
// Directed bench for hs_ram_port with a behavioural bank model and a read-data scoreboard.
module tb_hs_ram_port;

   logic        clock_18 = 1'b0;
   logic        reset;
   logic        hs_access;
   logic [15:0] hs_address;
   logic [7:0]  hs_data_in;
   logic        hs_write;
   logic [7:0]  hs_data_out;
   logic        hs_granted;
   logic        hs_drop;
   logic        cpu_halted;
   logic [9:0]  cpu_addr;
   logic [7:0]  cpu_din;
   logic [2:0]  cpu_we;
   logic [9:0]  ram_addr;
   logic [7:0]  ram_din;
   logic [2:0]  ram_we;
   logic [23:0] ram_dout;

   bit [7:0] mem    [3][1024];
   bit [7:0] shadow [3][1024];

   typedef struct {
      logic        chk;
      logic [15:0] addr;
      logic [7:0]  val;
   } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clock_18 = ~clock_18;

   hs_ram_port dut (
      .clock_18    (clock_18),
      .reset       (reset),
      .hs_access   (hs_access),
      .hs_address  (hs_address),
      .hs_data_in  (hs_data_in),
      .hs_write    (hs_write),
      .hs_data_out (hs_data_out),
      .hs_granted  (hs_granted),
      .hs_drop     (hs_drop),
      .cpu_halted  (cpu_halted),
      .cpu_addr    (cpu_addr),
      .cpu_din     (cpu_din),
      .cpu_we      (cpu_we),
      .ram_addr    (ram_addr),
      .ram_din     (ram_din),
      .ram_we      (ram_we),
      .ram_dout    (ram_dout)
   );

   // Three 1 KB banks with synchronous read.
   always @(posedge clock_18) begin
      for (int b = 0; b < 3; b++) begin
         if (ram_we[b] === 1'b1) mem[b][ram_addr] <= ram_din;
         ram_dout[8*b +: 8] <= mem[b][ram_addr];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_win(input logic [15:0] a);
      int unsigned o;
      if (a < 16'h8000) return 1'b0;
      o = 32'(a) - 32'h8000;
      return (o < 3 * 2048) && ((o % 2048) < 1024);
   endfunction

   function automatic logic [7:0] model_read(input logic [15:0] a);
      int unsigned o;
      if (!model_win(a)) return 8'h00;
      o = 32'(a) - 32'h8000;
      return shadow[o / 2048][o % 2048];
   endfunction

   task automatic step();
      @(posedge clock_18);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   // One hiscore bus cycle; read data for cycle t is compared at the sample point of t+2.
   task automatic hs_cycle(input logic [15:0] addr, input logic wr, input logic [7:0] wdata,
                           input logic chk);
      exp_t        e;
      int unsigned o;
      step();
      hs_address = addr;
      hs_write   = wr;
      hs_data_in = wdata;
      e.chk  = chk;
      e.addr = addr;
      e.val  = model_read(addr);
      exp_q.push_back(e);
      if (wr && model_win(addr)) begin
         o = 32'(addr) - 32'h8000;
         shadow[o / 2048][o % 2048] = wdata;
      end
      settle();
      if (exp_q.size() > 2) begin
         e = exp_q.pop_front();
         if (e.chk) check($sformatf("rd_%04h", e.addr), 32'(hs_data_out), 32'(e.val));
      end
   endtask

   task automatic wait_grant();
      for (int i = 0; i < 20 && hs_granted !== 1'b1; i++) begin
         step();
         settle();
      end
      check("grant_wait", 32'(hs_granted), 32'd1);
   endtask

   initial begin
      reset      = 1'b1;
      hs_access  = 1'b0;
      hs_address = '0;
      hs_data_in = '0;
      hs_write   = 1'b0;
      cpu_halted = 1'b0;
      cpu_addr   = '0;
      cpu_din    = '0;
      cpu_we     = '0;
      repeat (2) step();
      reset = 1'b0;
      settle();
      check("rst_granted", 32'(hs_granted), 32'd0);
      check("rst_drop", 32'(hs_drop), 32'd0);
      check("rst_dout", 32'(hs_data_out), 32'd0);
      check("rst_we", 32'(ram_we), 32'd0);

      // CPU passthrough
      step();
      cpu_we   = 3'b010;
      cpu_addr = 10'h155;
      cpu_din  = 8'h3C;
      shadow[1][10'h155] = 8'h3C;
      settle();
      check("cpu_we", 32'(ram_we), 32'b010);
      check("cpu_addr", 32'(ram_addr), 32'h155);
      check("cpu_din", 32'(ram_din), 32'h3C);
      check("cpu_granted", 32'(hs_granted), 32'd0);

      // Grant timing: cycle 0 is IDLE, then GUARD halted cycles in DRAIN
      step();
      cpu_we     = '0;
      hs_access  = 1'b1;
      cpu_halted = 1'b1;
      settle();
      check("grant_c0", 32'(hs_granted), 32'd0);
      for (int c = 1; c <= 6; c++) begin
         step();
         settle();
         check($sformatf("grant_c%0d", c), 32'(hs_granted), 32'(c >= 5));
      end
      step();
      cpu_halted = 1'b0;
      settle();
      check("halt_drop_keeps", 32'(hs_granted), 32'd1);
      step();
      settle();
      check("halt_drop_keeps2", 32'(hs_granted), 32'd1);
      step();
      hs_access = 1'b0;
      settle();
      check("release_last", 32'(hs_granted), 32'd1);
      step();
      settle();
      check("release_off", 32'(hs_granted), 32'd0);

      // Halt pulse after two guard cycles: those plus the low cycle are lost
      step();
      hs_access  = 1'b1;
      cpu_halted = 1'b1;
      settle();
      for (int c = 1; c <= 9; c++) begin
         step();
         cpu_halted = (c != 3);
         settle();
         check($sformatf("pulse_c%0d", c), 32'(hs_granted), 32'(c >= 8));
      end
      step();
      hs_access = 1'b0;
      settle();
      step();
      settle();

      // Write while draining is dropped; CPU write still passes through
      step();
      hs_access  = 1'b1;
      cpu_halted = 1'b0;
      settle();
      step();
      hs_write   = 1'b1;
      hs_address = 16'h8803;
      hs_data_in = 8'hEE;
      cpu_we     = 3'b100;
      cpu_addr   = 10'h0AA;
      cpu_din    = 8'h11;
      shadow[2][10'h0AA] = 8'h11;
      settle();
      check("drain_we", 32'(ram_we), 32'b100);
      check("drain_addr", 32'(ram_addr), 32'h0AA);
      check("drain_din", 32'(ram_din), 32'h11);
      step();
      hs_write = 1'b0;
      cpu_we   = '0;
      settle();
      check("drain_drop", 32'(hs_drop), 32'd1);
      step();
      reset = 1'b1;
      settle();
      step();
      reset     = 1'b0;
      hs_access = 1'b0;
      settle();
      check("drop_cleared", 32'(hs_drop), 32'd0);

      // Granted session: writes, reads, window edges
      step();
      hs_access  = 1'b1;
      cpu_halted = 1'b1;
      settle();
      wait_grant();
      exp_q.delete();
      cpu_we   = 3'b111;
      cpu_addr = 10'h2AA;
      cpu_din  = 8'hFF;
      hs_cycle(16'h8803, 1'b1, 8'hA5, 1'b0);
      check("wr_we", 32'(ram_we), 32'b010);
      check("wr_addr", 32'(ram_addr), 32'h003);
      check("wr_din", 32'(ram_din), 32'hA5);
      hs_cycle(16'h8803, 1'b0, 8'h00, 1'b1);
      check("rd_cpu_masked", 32'(ram_we), 32'd0);
      cpu_we = '0;
      hs_cycle(16'h8000, 1'b1, 8'h5A, 1'b0);
      check("wr0_we", 32'(ram_we), 32'b001);
      hs_cycle(16'h93FF, 1'b1, 8'h77, 1'b0);
      check("wr2_we", 32'(ram_we), 32'b100);
      check("wr2_addr", 32'(ram_addr), 32'h3FF);
      hs_cycle(16'h8000, 1'b0, 8'h00, 1'b1);
      hs_cycle(16'h93FF, 1'b0, 8'h00, 1'b1);
      hs_cycle(16'h8400, 1'b0, 8'h00, 1'b1);
      check("mirror_we", 32'(ram_we), 32'd0);
      hs_cycle(16'h9800, 1'b0, 8'h00, 1'b1);
      hs_cycle(16'h7FFF, 1'b0, 8'h00, 1'b1);
      hs_cycle(16'h8804, 1'b0, 8'h00, 1'b1);
      check("no_drop_yet", 32'(hs_drop), 32'd0);
      hs_cycle(16'h9800, 1'b1, 8'hC3, 1'b0);
      check("oow_wr_we", 32'(ram_we), 32'd0);
      hs_cycle(16'h8803, 1'b0, 8'h00, 1'b1);
      check("oow_drop", 32'(hs_drop), 32'd1);
      hs_cycle(16'h8803, 1'b0, 8'h00, 1'b1);
      hs_access = 1'b0;
      hs_cycle(16'h8000, 1'b0, 8'h00, 1'b0);
      hs_cycle(16'h8000, 1'b0, 8'h00, 1'b0);
      hs_cycle(16'h8000, 1'b0, 8'h00, 1'b0);
      check("dout_holds", 32'(hs_data_out), 32'hA5);
      check("drop_sticky", 32'(hs_drop), 32'd1);

      // Reset while granted and writing
      hs_access = 1'b1;
      wait_grant();
      step();
      hs_write   = 1'b1;
      hs_address = 16'h8803;
      hs_data_in = 8'h99;
      reset      = 1'b1;
      settle();
      check("rstg_we", 32'(ram_we), 32'd0);
      check("rstg_granted", 32'(hs_granted), 32'd0);
      step();
      reset = 1'b0;
      settle();
      check("rstg_we_after", 32'(ram_we), 32'd0);
      check("rstg_granted_after", 32'(hs_granted), 32'd0);
      // Regrant timing shows the FSM restarted from IDLE
      for (int c = 1; c <= 5; c++) begin
         step();
         hs_write = 1'b0;
         settle();
         check($sformatf("regrant_c%0d", c), 32'(hs_granted), 32'(c == 5));
      end
      exp_q.delete();
      hs_cycle(16'h8803, 1'b0, 8'h00, 1'b1);
      hs_cycle(16'h8803, 1'b0, 8'h00, 1'b0);
      hs_cycle(16'h8803, 1'b0, 8'h00, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
